// File: rtl/alu_exec_unit.sv
// ALU execute stage: alu_op/funct decode, single-cycle ALU ops and an iterative
// shift-add MULT/MULTU, with a valid/ready handshake on both sides.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter bit MUL_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_op,
    input  logic [5:0]         func_code,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               zero,
    output logic               overflow,
    output logic               illegal
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [4:0] {
        OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MULT, OP_MULTU, OP_ILL
    } op_e;
    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 neg_q, neg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     res_q, res_d, hi_q, hi_d;
    logic                 zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d, vld_q, vld_d;

    op_e                  op;
    logic                 accept, is_mul, signed_mul, alu_ovf;
    logic [WIDTH-1:0]     sum, diff, alu_res, a_mag, b_mag;
    logic [2*WIDTH-1:0]   acc_step, prod;

    always_comb begin
        op = OP_ILL;
        case (alu_op)
            4'b0000: op = OP_AND;
            4'b0001: op = OP_OR;
            4'b0010: op = OP_ADD;
            4'b0011: op = OP_SLL;
            4'b0100: op = OP_SRL;
            4'b0110: op = OP_SUB;
            4'b0111: op = OP_SLT;
            4'b1000: op = OP_ADDU;
            4'b1001: op = OP_SUBU;
            4'b1010: op = OP_XOR;
            4'b1011: op = OP_SLTU;
            4'b1100: op = OP_NOR;
            4'b1101: op = OP_SRA;
            4'b1110: op = OP_LUI;
            4'b1111: begin
                case (func_code)
                    6'b000000: op = OP_SLL;
                    6'b000010: op = OP_SRL;
                    6'b000011: op = OP_SRA;
                    6'b100000: op = OP_ADD;
                    6'b100001: op = OP_ADDU;
                    6'b100010: op = OP_SUB;
                    6'b100011: op = OP_SUBU;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b101011: op = OP_SLTU;
                    6'b011000: op = MUL_EN ? OP_MULT : OP_ILL;
                    6'b011001: op = MUL_EN ? OP_MULTU : OP_ILL;
                    default:   op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    assign sum  = a + b;
    assign diff = a - b;

    // Illegal ops fall through to the zero result, which also makes zero=1.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: alu_res = diff;
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: alu_res = WIDTH'(a < b);
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = $signed(b) >>> shamt;
            OP_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: alu_res = '0;
        endcase
    end

    assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
    assign signed_mul = (op == OP_MULT);
    assign a_mag      = (signed_mul && a[WIDTH-1]) ? -a : a;
    assign b_mag      = (signed_mul && b[WIDTH-1]) ? -b : b;
    assign acc_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod       = neg_q ? -acc_q : acc_q;

    assign in_ready = (state_q == S_IDLE) && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        vld_d    = vld_q && !out_ready;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = signed_mul && (a[WIDTH-1] ^ b[WIDTH-1]);
                    cnt_d    = '0;
                    state_d  = S_MUL;
                end else if (accept) begin
                    res_d  = alu_res;
                    hi_d   = '0;
                    zero_d = (alu_res == '0);
                    ovf_d  = alu_ovf;
                    ill_d  = (op == OP_ILL);
                    vld_d  = 1'b1;
                end
            end
            S_MUL: begin
                if (cnt_q != CNT_W'(WIDTH)) begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end else if (!vld_q || out_ready) begin
                    // Finish only once any older result has left, so it is never overwritten.
                    {hi_d, res_d} = prod;
                    zero_d  = (prod == '0);
                    ovf_d   = 1'b0;
                    ill_d   = 1'b0;
                    vld_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            vld_q    <= vld_d;
        end
    end

    assign out_valid = vld_q;
    assign result    = res_q;
    assign result_hi = hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: accepted requests push a model result,
// the monitor compares every presented output against the queue head.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  alu_op;
    logic [5:0]  func_code;
    logic [4:0]  shamt;
    logic [31:0] a, b, result, result_hi;
    logic        zero, overflow, illegal;

    typedef struct {
        logic [31:0] r;
        logic [31:0] h;
        logic        z;
        logic        o;
        logic        i;
    } exp_t;

    exp_t q[$];
    int   errs = 0, checks = 0, cyc = 0;
    bit   rdy_rand = 0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .func_code(func_code), .shamt(shamt), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .result_hi(result_hi), .zero(zero), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model straight from the op table, using wide integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [5:0] fn,
                                   input logic [4:0] sh, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int k;
        longint sx, sy, s;
        logic [63:0] p;
        e = '{r: '0, h: '0, z: 1'b0, o: 1'b0, i: 1'b0};
        k = int'(op);
        p = '0;
        if (op == 4'hF) begin
            case (fn)
                6'h00: k = 3;   6'h02: k = 4;   6'h03: k = 13;
                6'h20: k = 2;   6'h21: k = 8;   6'h22: k = 6;   6'h23: k = 9;
                6'h24: k = 0;   6'h25: k = 1;   6'h26: k = 10;  6'h27: k = 12;
                6'h2A: k = 7;   6'h2B: k = 11;  6'h18: k = 16;  6'h19: k = 17;
                default: k = -1;
            endcase
        end
        if (op == 4'h5) k = -1;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (k)
            0:  e.r = x & y;
            1:  e.r = x | y;
            2:  begin e.r = x + y; s = sx + sy; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3:  e.r = y << sh;
            4:  e.r = y >> sh;
            6:  begin e.r = x - y; s = sx - sy; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            7:  e.r = (sx < sy) ? 32'd1 : 32'd0;
            8:  e.r = x + y;
            9:  e.r = x - y;
            10: e.r = x ^ y;
            11: e.r = (x < y) ? 32'd1 : 32'd0;
            12: e.r = ~(x | y);
            13: begin s = sy >>> sh; e.r = s[31:0]; end
            14: e.r = {y[15:0], 16'h0000};
            16: p = sx * sy;
            17: p = {32'h0, x} * {32'h0, y};
            default: e.i = 1'b1;
        endcase
        if (k == 16 || k == 17) begin
            e.r = p[31:0];
            e.h = p[63:32];
            e.z = (p == 64'h0);
        end else begin
            e.z = (e.r == 32'h0);
        end
        return e;
    endfunction

    // Acceptor: every handshake pushes its expected response.
    always @(negedge clk) begin
        if (reset_n && in_valid && in_ready)
            q.push_back(model(alu_op, func_code, shamt, a, b));
    end

    // Monitor: the presented output must match the queue head for as long as it is shown.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {63'h0, out_valid}, 64'h0);
            end else begin
                chk("result", result, q[0].r);
                chk("result_hi", result_hi, q[0].h);
                chk("zero", zero, q[0].z);
                chk("overflow", overflow, q[0].o);
                chk("illegal", illegal, q[0].i);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Entered and left at 1 time unit after a rising edge; leaves in_valid high.
    task automatic issue(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] x, input logic [31:0] y);
        int n;
        alu_op = op; func_code = fn; shamt = sh; a = x; b = y;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 64'(n), 64'h0);
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 64'(q.size()), 64'h0);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, t0;
        logic [5:0] fl[15];
        logic [3:0] rop;
        logic [5:0] rfn;
        fl = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
               6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h18, 6'h19};
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; func_code = '0; shamt = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_result_hi", result_hi, 32'h0);
        chk("rst_flags", {zero, overflow, illegal}, 3'b000);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // ADD overflow then ADDU, single-cycle latency
        issue(4'b0010, 6'h0, 5'd0, 32'h7FFFFFFF, 32'h1);
        chk("add_latency", out_valid, 1'b1);
        chk("add_result", result, 32'h80000000);
        chk("add_ovf", overflow, 1'b1);
        issue(4'b1000, 6'h0, 5'd0, 32'h7FFFFFFF, 32'h1);
        issue(4'hF, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'h1);
        issue(4'hF, 6'b101011, 5'd0, 32'hFFFFFFFF, 32'h1);
        issue(4'b1101, 6'h0, 5'd4, 32'h0, 32'h80000000);
        chk("sra_result", result, 32'hF8000000);
        issue(4'b0100, 6'h0, 5'd4, 32'h0, 32'h80000000);
        issue(4'b1110, 6'h0, 5'd0, 32'h0, 32'h00001234);
        chk("lui_result", result, 32'h12340000);
        issue(4'b0011, 6'h0, 5'd0, 32'h0, 32'hA5A5_0F0F);
        in_valid = 1'b0;
        drain();

        // MULT -3*7 with a second request held pending
        issue(4'hF, 6'b011000, 5'd0, 32'hFFFFFFFD, 32'd7);
        alu_op = 4'b1000; func_code = 6'h0; a = 32'd1; b = 32'd2;
        in_valid = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (out_valid) break;
            chk("mul_busy_in_ready", in_ready, 1'b0);
            @(posedge clk);
            n++;
        end
        chk("mul_latency", 64'(n), 64'd33);
        chk("mult_hi", result_hi, 32'hFFFFFFFF);
        chk("mult_lo", result, 32'hFFFFFFEB);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        issue(4'hF, 6'b011000, 5'd0, 32'h80000000, 32'hFFFFFFFF);
        issue(4'hF, 6'b011001, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        in_valid = 1'b0;
        drain();

        // Back-to-back throughput, then a 3-cycle stall
        t0 = cyc;
        issue(4'b0000, 6'h0, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00);
        issue(4'b0001, 6'h0, 5'd0, 32'hF0F0F0F0, 32'h0000FFFF);
        issue(4'b1010, 6'h0, 5'd0, 32'hF0F0F0F0, 32'h0F0F0F0F);
        chk("throughput", 64'(cyc - t0), 64'd3);
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(4'hF, 6'b111111, 5'd0, 32'h1234, 32'h5678);
        chk("illegal_flag", illegal, 1'b1);
        issue(4'b0101, 6'h0, 5'd0, 32'h1, 32'h1);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a multiply
        issue(4'hF, 6'b011001, 5'd0, 32'h12345678, 32'h9ABCDEF0);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("midmul_rst_out_valid", out_valid, 1'b0);
        chk("midmul_rst_result", result, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        issue(4'b0110, 6'h0, 5'd0, 32'd5, 32'd7);
        chk("sub_after_rst", result, 32'hFFFFFFFE);
        in_valid = 1'b0;
        drain();

        // Random traffic with random back-pressure
        rdy_rand = 1;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            rop = 4'($urandom_range(0, 15));
            rfn = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) rfn = fl[$urandom_range(0, 14)];
            if ($urandom_range(0, 9) == 0) begin
                rop = 4'hF;
                rfn = ($urandom_range(0, 1) == 0) ? 6'h18 : 6'h19;
            end
            issue(rop, rfn, 5'($urandom_range(0, 31)), rnd32(), rnd32());
        end
        in_valid = 1'b0;
        rdy_rand = 0;
        out_ready = 1'b1;
        drain();
        chk("final_out_valid", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised ALU execute stage that merges ALU-control decode with the datapath. It accepts an operation as (alu_op, func_code) plus operands over a valid/ready handshake. It returns a registered result with status flags. It extends the existing op set with iterative signed/unsigned multiply (MULT/MULTU) producing a double-width HI/LO result. It sits between the register-read stage and writeback in the MIPS datapath.

Parameters:
WIDTH, 32, operand/result width; must be even and >= 8
SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH)
MUL_EN, 1, 1 = MULT/MULTU supported; 0 = those funct codes are illegal

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request valid
in_ready  out  1  unit can accept an operation this cycle
alu_op  in  4  AND=0000 OR=0001 ADD=0010 SLL=0011 SRL=0100 SUB=0110 SLT=0111 ADDU=1000 SUBU=1001 XOR=1010 SLTU=1011 NOR=1100 SRA=1101 LUI=1110 FUNC=1111
func_code  in  6  R-type funct; used only when alu_op=FUNC
shamt  in  SHAMT_W  shift amount for SLL/SRL/SRA
a  in  WIDTH  operand A (rs)
b  in  WIDTH  operand B (rt/imm); the shifted operand for shifts
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  result; LO half for multiply
result_hi  out  WIDTH  HI half for multiply; 0 for all other ops
zero  out  1  result==0 (multiply: full 2*WIDTH product==0)
overflow  out  1  signed overflow; only ADD/SUB can set it
illegal  out  1  alu_op=FUNC with an unsupported funct

Behaviour:
- Reset (async, reset_n=0): state=IDLE; out_valid, result, result_hi, zero, overflow and illegal all 0. in_ready is 1 after reset deasserts. Reset during a multiply aborts it with no output.
- Decode: alu_op!=FUNC selects that op directly. For alu_op=FUNC:
  - 000000 SLL, 000010 SRL, 000011 SRA
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
  - 101010 SLT, 101011 SLTU
  - 011000 MULT, 011001 MULTU (when MUL_EN=1)
  - any other funct, and alu_op=0101, is illegal.
- Arithmetic:
  - Add/sub wrap modulo 2^WIDTH.
  - overflow=1 for ADD/SUB on signed overflow: operand signs match (ADD) or differ (SUB) and the result sign differs from a.
  - SLT is a signed compare, SLTU unsigned; result = {0..,a<b}.
  - SLL/SRL/SRA shift b by shamt; SRA replicates b[WIDTH-1].
  - LUI: result = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - NOR = ~(a|b).
- Illegal op: completes as a single-cycle op with result=0, result_hi=0, zero=1, overflow=0, illegal=1.
- Handshake:
  - Transfer occurs when in_valid&&in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output is held stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new result loads in the same cycle; back-to-back single-cycle ops sustain 1 op/cycle.
- State machine IDLE / MUL:
  - IDLE, accept of a non-multiply op: result and flags register at the next edge, out_valid=1 (latency 1).
  - IDLE, accept of MULT/MULTU: capture a and b. For MULT, convert to magnitudes and record the sign as a[W-1]^b[W-1]. Clear the 2W accumulator, count=0, go to MUL; in_ready=0.
  - MUL: one shift-add step per cycle over WIDTH cycles. At the last step, negate the product if the sign was set, load {result_hi,result}, set out_valid=1, return to IDLE.
  - Multiply latency: out_valid rises WIDTH+1 cycles after the accept edge.
- Boundaries:
  - shamt=0 passes b unchanged.
  - 0x80000000 * 0xFFFFFFFF under MULT gives HI=0x00000000, LO=0x80000000.
  - MULTU of all-ones: HI=0xFFFFFFFE, LO=0x00000001.
  - in_valid during MUL is ignored (in_ready=0).

Test Plan:
- ADD a=0x7FFFFFFF b=1 (alu_op=0010) -> 1 cycle later result=0x80000000, overflow=1, zero=0; ADDU same operands -> overflow=0.
- FUNC/101010 SLT a=0xFFFFFFFF b=1 -> result=1; FUNC/101011 SLTU same operands -> result=0, zero=1.
- SRA b=0x80000000 shamt=4 -> 0xF8000000; SRL -> 0x08000000; LUI b=0x00001234 -> 0x12340000.
- MULT a=-3 b=7 -> after 33 cycles out_valid=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB; in_ready=0 throughout; a second request held on in_valid is accepted only after completion.
- Back-to-back AND/OR/XOR with out_ready=1 -> one result per cycle; then out_ready=0 for 3 cycles -> result stable, in_ready=0; FUNC/111111 -> illegal=1, result=0.
- Assert reset_n=0 mid-MULT (cycle 10) -> out_valid=0 immediately; after release a new SUB 5-7 -> result=0xFFFFFFFE.
